// File: rtl/fifo_wr_sched_if.sv
// Write-scheduler bus: requester-side request/data signals plus the FIFO
// write-port pins (req/burst_len/i_data/full in, gnt/data_ack/done/w_en/
// data_out/busy out). "master" is the scheduler, "slave" is the attached
// requesters + FIFO.
interface fifo_wr_sched_if #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned LW         = 11
);
    logic [NUM_REQ-1:0]            req;
    logic [NUM_REQ*LW-1:0]         burst_len;
    logic [NUM_REQ*DATA_WIDTH-1:0] i_data;
    logic                          full;
    logic [NUM_REQ-1:0]            gnt;
    logic [NUM_REQ-1:0]            data_ack;
    logic [NUM_REQ-1:0]            done;
    logic                          w_en;
    logic [DATA_WIDTH-1:0]         data_out;
    logic                          busy;

    modport master (
        input  req, burst_len, i_data, full,
        output gnt, data_ack, done, w_en, data_out, busy
    );

    modport slave (
        output req, burst_len, i_data, full,
        input  gnt, data_ack, done, w_en, data_out, busy
    );
endinterface

// File: rtl/fifo_wr_sched.sv
// Round-robin scheduler sharing one FIFO write port among NUM_REQ requesters.
// Each grant runs one full burst, with WR_IDLE idle cycles between writes and
// writes held off while FULL is high.
// Ports: clk, rst (sync, active-high), bus (fifo_wr_sched_if.master):
//   req/burst_len/i_data per requester, full from the FIFO;
//   gnt/done/busy registered; w_en/data_out/data_ack combinational.
module fifo_wr_sched #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned MAX_BURST  = 1024,
    parameter int unsigned WR_IDLE    = 2
) (
    input  logic            clk,
    input  logic            rst,
    fifo_wr_sched_if.master bus
);
    localparam int unsigned LW = $clog2(MAX_BURST) + 1;
    localparam int unsigned PW = $clog2(NUM_REQ);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_BURST = 2'd1;
    localparam logic [1:0] S_GAP   = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [LW-1:0] LEN_MAX  = LW'(MAX_BURST);
    localparam logic [3:0]    GAP_LOAD = 4'(WR_IDLE);

    logic [1:0]         state_q, state_d;
    logic [PW-1:0]      win_q, win_d;
    logic [PW-1:0]      ptr_q, ptr_d;
    logic [LW-1:0]      rem_q, rem_d;
    logic [3:0]         gap_q, gap_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic [NUM_REQ-1:0] done_q, done_d;
    logic               busy_q, busy_d;

    logic [LW-1:0]         len_arr  [NUM_REQ];
    logic [DATA_WIDTH-1:0] data_arr [NUM_REQ];
    logic [NUM_REQ-1:0]    elig;

    // Unpack per-requester slices; zero-length requests are never eligible
    for (genvar g = 0; g < NUM_REQ; g++) begin : g_slice
        assign len_arr[g]  = bus.burst_len[g*LW +: LW];
        assign data_arr[g] = bus.i_data[g*DATA_WIDTH +: DATA_WIDTH];
        assign elig[g]     = bus.req[g] && (len_arr[g] != '0);
    end

    // Round-robin search starting at ptr_q, wrapping modulo NUM_REQ
    logic          found_c;
    logic [PW-1:0] pick_c;
    logic [PW:0]   idx_c;

    always_comb begin
        found_c = 1'b0;
        pick_c  = '0;
        idx_c   = '0;
        for (int unsigned j = 0; j < NUM_REQ; j++) begin
            idx_c = {1'b0, ptr_q} + (PW+1)'(j);
            if (idx_c >= (PW+1)'(NUM_REQ)) begin
                idx_c = idx_c - (PW+1)'(NUM_REQ);
            end
            if (!found_c && elig[idx_c[PW-1:0]]) begin
                found_c = 1'b1;
                pick_c  = idx_c[PW-1:0];
            end
        end
    end

    // Over-long requests are clamped when latched
    logic [LW-1:0] pick_len_c;
    assign pick_len_c = (len_arr[pick_c] > LEN_MAX) ? LEN_MAX : len_arr[pick_c];

    // A write happens in any BURST cycle the FIFO is not full
    logic w_en_c;
    assign w_en_c = (state_q == S_BURST) && !bus.full;

    function automatic logic [NUM_REQ-1:0] onehot(input logic [PW-1:0] w);
        return NUM_REQ'(1) << w;
    endfunction

    // Next-state and registered-output decode
    always_comb begin
        state_d = state_q;
        win_d   = win_q;
        ptr_d   = ptr_q;
        rem_d   = rem_q;
        gap_d   = gap_q;
        case (state_q)
            S_IDLE: begin
                if (found_c) begin
                    win_d   = pick_c;
                    rem_d   = pick_len_c;
                    state_d = S_BURST;
                end
            end
            S_BURST: begin
                if (w_en_c) begin
                    rem_d = rem_q - LW'(1);
                    if (rem_q == LW'(1)) begin
                        state_d = S_DONE;
                    end else if (GAP_LOAD != 4'd0) begin
                        gap_d   = GAP_LOAD;
                        state_d = S_GAP;
                    end
                end
            end
            S_GAP: begin
                gap_d = gap_q - 4'd1;
                if (gap_q == 4'd1) begin
                    state_d = S_BURST;
                end
            end
            S_DONE: begin
                ptr_d   = (win_q == PW'(NUM_REQ - 1)) ? '0 : win_q + PW'(1);
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        gnt_d  = ((state_d == S_BURST) || (state_d == S_GAP)) ? onehot(win_d) : '0;
        done_d = (state_d == S_DONE) ? onehot(win_d) : '0;
        busy_d = (state_d != S_IDLE);
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            win_q   <= '0;
            ptr_q   <= '0;
            rem_q   <= '0;
            gap_q   <= '0;
            gnt_q   <= '0;
            done_q  <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            win_q   <= win_d;
            ptr_q   <= ptr_d;
            rem_q   <= rem_d;
            gap_q   <= gap_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    assign bus.gnt      = gnt_q;
    assign bus.done     = done_q;
    assign bus.busy     = busy_q;
    assign bus.w_en     = w_en_c;
    assign bus.data_ack = gnt_q & {NUM_REQ{w_en_c}};
    assign bus.data_out = (gnt_q != '0) ? data_arr[win_q] : '0;

endmodule

// File: tb/tb_fifo_wr_sched.sv
// Scoreboard bench for fifo_wr_sched: dut_a (WR_IDLE=2) covers reset,
// round robin, single burst, reset mid-burst, zero-length/clamp and a FIFO
// end-to-end run; dut_b (WR_IDLE=0) covers FULL throttling.
module tb_fifo_wr_sched;
    localparam int unsigned DW    = 8;
    localparam int unsigned NR    = 4;
    localparam int unsigned MB    = 1024;
    localparam int unsigned LW    = 11;
    localparam int unsigned DEPTH = 333;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fifo_wr_sched_if #(.DATA_WIDTH(DW), .NUM_REQ(NR), .LW(LW)) bus_a ();
    fifo_wr_sched_if #(.DATA_WIDTH(DW), .NUM_REQ(NR), .LW(LW)) bus_b ();

    fifo_wr_sched #(.DATA_WIDTH(DW), .NUM_REQ(NR), .MAX_BURST(MB), .WR_IDLE(2)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a)
    );

    fifo_wr_sched #(.DATA_WIDTH(DW), .NUM_REQ(NR), .MAX_BURST(MB), .WR_IDLE(0)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b)
    );

    typedef struct { int unsigned cyc; int unsigned idx; logic [DW-1:0] data; } wr_t;
    typedef struct { int unsigned cyc; int unsigned idx; } dn_t;

    wr_t         wq [2][$];
    dn_t         dq [2][$];
    int          n_chk = 0;
    int          n_fail = 0;
    int unsigned cyc = 0;
    int unsigned issued [2][NR];
    int unsigned ctr_a [NR];
    int unsigned ctr_b [NR];
    logic        full_force;
    logic        e2e_on;
    int unsigned fifo_cnt = 0;
    int unsigned popped = 0;
    logic        overflow = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [DW-1:0] word(input int unsigned r, input int unsigned n);
        return DW'(r * 64 + n);
    endfunction

    function automatic logic [NR*LW-1:0] lens(input int unsigned l0, input int unsigned l1,
                                              input int unsigned l2, input int unsigned l3);
        return {LW'(l3), LW'(l2), LW'(l1), LW'(l0)};
    endfunction

    // Requesters: each presents word(i, n) and advances after an accepted word
    always @(posedge clk) begin
        for (int i = 0; i < NR; i++) begin
            if (rst) begin
                ctr_a[i] <= 0;
                ctr_b[i] <= 0;
            end else begin
                if (bus_a.data_ack[i]) ctr_a[i] <= ctr_a[i] + 1;
                if (bus_b.data_ack[i]) ctr_b[i] <= ctr_b[i] + 1;
            end
        end
    end

    for (genvar g = 0; g < NR; g++) begin : g_req
        assign bus_a.i_data[g*DW +: DW] = word(g, ctr_a[g]);
        assign bus_b.i_data[g*DW +: DW] = word(g, ctr_b[g]);
    end

    // FIFO occupancy model with a consumer popping every 4th cycle
    always @(posedge clk) begin
        if (rst || !e2e_on) begin
            fifo_cnt <= 0;
        end else begin
            fifo_cnt <= fifo_cnt + (bus_a.w_en ? 1 : 0)
                        - ((fifo_cnt != 0 && cyc % 4 == 0) ? 1 : 0);
            if (fifo_cnt != 0 && cyc % 4 == 0) popped <= popped + 1;
            if (bus_a.w_en && fifo_cnt >= DEPTH) overflow <= 1'b1;
        end
    end

    assign bus_a.full = e2e_on ? (fifo_cnt >= DEPTH) : full_force;

    task automatic chk(input string name, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_wr(input int inst, input int unsigned c, input int unsigned r);
        wq[inst].push_back('{cyc: c, idx: r, data: word(r, issued[inst][r])});
        issued[inst][r]++;
    endtask

    task automatic push_dn(input int inst, input int unsigned c, input int unsigned r);
        dq[inst].push_back('{cyc: c, idx: r});
    endtask

    // Compares one cycle of DUT outputs against the head of its queues
    task automatic mon(input int inst, input logic w_en, input logic [NR-1:0] gnt,
                       input logic [NR-1:0] ack, input logic [NR-1:0] done,
                       input logic [DW-1:0] dout);
        wr_t e;
        dn_t d;
        if (w_en) begin
            if (wq[inst].size() == 0) begin
                chk($sformatf("dut%0d unexpected write", inst), 1, 0);
            end else begin
                e = wq[inst].pop_front();
                chk($sformatf("dut%0d write gnt", inst), gnt, 64'(1) << e.idx);
                chk($sformatf("dut%0d write ack", inst), ack, 64'(1) << e.idx);
                chk($sformatf("dut%0d write data", inst), dout, e.data);
                if (e.cyc != 0) chk($sformatf("dut%0d write cycle", inst), cyc, e.cyc);
            end
        end else if (ack != '0) begin
            chk($sformatf("dut%0d ack without w_en", inst), ack, 0);
        end
        if (done != '0) begin
            if (dq[inst].size() == 0) begin
                chk($sformatf("dut%0d unexpected done", inst), done, 0);
            end else begin
                d = dq[inst].pop_front();
                chk($sformatf("dut%0d done vector", inst), done, 64'(1) << d.idx);
                if (d.cyc != 0) chk($sformatf("dut%0d done cycle", inst), cyc, d.cyc);
            end
        end
    endtask

    task automatic drain(input int inst, input int budget, input string name);
        int n = 0;
        while ((wq[inst].size() + dq[inst].size()) != 0 && n < budget) begin
            tick();
            n++;
        end
        chk(name, wq[inst].size() + dq[inst].size(), 0);
    endtask

    task automatic clear_issued();
        for (int i = 0; i < 2; i++)
            for (int r = 0; r < NR; r++) issued[i][r] = 0;
    endtask

    initial begin
        int unsigned base;
        int          n;

        rst             = 1'b1;
        bus_a.req       = '0;
        bus_a.burst_len = '0;
        bus_b.req       = '0;
        bus_b.burst_len = '0;
        bus_b.full      = 1'b0;
        full_force      = 1'b0;
        e2e_on          = 1'b0;
        clear_issued();

        fork
            forever begin
                @(negedge clk);
                mon(0, bus_a.w_en, bus_a.gnt, bus_a.data_ack, bus_a.done, bus_a.data_out);
                mon(1, bus_b.w_en, bus_b.gnt, bus_b.data_ack, bus_b.done, bus_b.data_out);
            end
        join_none

        // Reset values
        repeat (3) tick();
        chk("reset gnt", bus_a.gnt, 0);
        chk("reset data_ack", bus_a.data_ack, 0);
        chk("reset done", bus_a.done, 0);
        chk("reset w_en", bus_a.w_en, 0);
        chk("reset data_out", bus_a.data_out, 0);
        chk("reset busy", bus_a.busy, 0);
        rst = 1'b0;
        tick();
        chk("idle busy", bus_a.busy, 0);

        // FULL throttling on dut_b: writes at 1, then 7..9 after FULL drops
        bus_b.burst_len = lens(4, 0, 0, 0);
        bus_b.req       = 4'b0001;
        base = cyc;
        push_wr(1, base + 1, 0);
        push_wr(1, base + 7, 0);
        push_wr(1, base + 8, 0);
        push_wr(1, base + 9, 0);
        push_dn(1, base + 10, 0);
        tick();
        bus_b.req = '0;
        for (int k = 2; k <= 6; k++) begin
            tick();
            bus_b.full = 1'b1;
            #2;
            chk("full: gnt held", bus_b.gnt, 1);
            chk("full: no w_en", bus_b.w_en, 0);
        end
        tick();
        bus_b.full = 1'b0;
        drain(1, 20, "full: burst drained");

        // Round robin, all lengths 2: order 0,1,2,3,0 every 6 cycles
        bus_a.burst_len = lens(2, 2, 2, 2);
        bus_a.req       = 4'b1111;
        base = cyc;
        for (int g = 0; g < 5; g++) begin
            push_wr(0, base + 1 + 6*g, g % 4);
            push_wr(0, base + 4 + 6*g, g % 4);
            push_dn(0, base + 5 + 6*g, g % 4);
        end
        repeat (26) tick();
        bus_a.req = '0;
        drain(0, 40, "rr: all bursts seen");

        // Single burst, requester 1, length 3
        bus_a.burst_len = lens(0, 3, 0, 0);
        bus_a.req       = 4'b0010;
        base = cyc;
        push_wr(0, base + 1, 1);
        push_wr(0, base + 4, 1);
        push_wr(0, base + 7, 1);
        push_dn(0, base + 8, 1);
        tick();
        bus_a.req = '0;
        repeat (8) tick();
        chk("single: busy low in cycle 9", bus_a.busy, 0);
        chk("single: gnt low in cycle 9", bus_a.gnt, 0);
        drain(0, 5, "single: burst drained");

        // Reset after 2nd of 5 writes by requester 2 (pointer is 2 here)
        bus_a.burst_len = lens(0, 0, 5, 0);
        bus_a.req       = 4'b0100;
        base = cyc;
        push_wr(0, base + 1, 2);
        push_wr(0, base + 4, 2);
        tick();
        bus_a.req = '0;
        repeat (4) tick();
        rst = 1'b1;
        tick();
        chk("rst mid: gnt", bus_a.gnt, 0);
        chk("rst mid: w_en", bus_a.w_en, 0);
        chk("rst mid: data_ack", bus_a.data_ack, 0);
        chk("rst mid: done", bus_a.done, 0);
        chk("rst mid: data_out", bus_a.data_out, 0);
        chk("rst mid: busy", bus_a.busy, 0);
        chk("rst mid: two writes before reset", wq[0].size(), 0);
        clear_issued();
        tick();
        rst = 1'b0;

        // After reset the pointer is 0: requester 0 wins over 2
        bus_a.burst_len = lens(1, 0, 1, 0);
        bus_a.req       = 4'b0101;
        base = cyc;
        push_wr(0, base + 1, 0);
        push_dn(0, base + 2, 0);
        push_wr(0, base + 4, 2);
        push_dn(0, base + 5, 2);
        tick();
        bus_a.req = 4'b0100;
        repeat (3) tick();
        bus_a.req = '0;
        drain(0, 10, "rst mid: post-reset order");

        // Zero length never granted; 2047 clamps to 1024 writes
        bus_a.burst_len = lens(0, 0, 0, 2047);
        bus_a.req       = 4'b1100;
        base = cyc;
        for (int k = 0; k < 1024; k++) push_wr(0, base + 1 + 3*k, 3);
        push_dn(0, base + 3071, 3);
        tick();
        tick();
        bus_a.req = 4'b0100;
        drain(0, 3200, "clamp: 1024 writes");
        repeat (10) tick();
        chk("zero length: no grant", bus_a.gnt, 0);
        chk("zero length: not busy", bus_a.busy, 0);
        bus_a.req = '0;

        // End-to-end through the FIFO model: two 1024-word bursts
        e2e_on          = 1'b1;
        bus_a.burst_len = lens(1024, 1024, 0, 0);
        bus_a.req       = 4'b0011;
        for (int k = 0; k < 1024; k++) push_wr(0, 0, 0);
        push_dn(0, 0, 0);
        for (int k = 0; k < 1024; k++) push_wr(0, 0, 1);
        push_dn(0, 0, 1);
        tick();
        tick();
        bus_a.req = 4'b0010;
        n = 0;
        while (bus_a.gnt != 4'b0010 && n < 20000) begin
            tick();
            n++;
        end
        chk("e2e: second grant", bus_a.gnt, 2);
        bus_a.req = '0;
        drain(0, 10000, "e2e: all writes seen");
        n = 0;
        while (popped < 2048 && n < 5000) begin
            tick();
            n++;
        end
        chk("e2e: consumer words", popped, 2048);
        chk("e2e: no overflow", overflow, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
